// File: rtl/kbd_playback_pkg.sv
// Shared key codes, FSM state encoding and key-match helper for the keyboard playback controller.
package kbd_playback_pkg;

  localparam logic [7:0] ASC_E_UP = 8'h45;
  localparam logic [7:0] ASC_E_LO = 8'h65;
  localparam logic [7:0] ASC_D_UP = 8'h44;
  localparam logic [7:0] ASC_D_LO = 8'h64;
  localparam logic [7:0] ASC_F_UP = 8'h46;
  localparam logic [7:0] ASC_F_LO = 8'h66;
  localparam logic [7:0] ASC_B_UP = 8'h42;
  localparam logic [7:0] ASC_B_LO = 8'h62;
  localparam logic [7:0] ASC_R_UP = 8'h52;
  localparam logic [7:0] ASC_R_LO = 8'h72;
  localparam logic [7:0] ASC_U_UP = 8'h55;
  localparam logic [7:0] ASC_U_LO = 8'h75;
  localparam logic [7:0] ASC_N_UP = 8'h4E;
  localparam logic [7:0] ASC_N_LO = 8'h6E;
  localparam logic [7:0] ASC_S_UP = 8'h53;
  localparam logic [7:0] ASC_S_LO = 8'h73;

  localparam logic [1:0] STATE_IDLE    = 2'd0;
  localparam logic [1:0] STATE_PLAY    = 2'd1;
  localparam logic [1:0] STATE_PAUSE   = 2'd2;
  localparam logic [1:0] STATE_RESTART = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = STATE_IDLE,
    ST_PLAY    = STATE_PLAY,
    ST_PAUSE   = STATE_PAUSE,
    ST_RESTART = STATE_RESTART
  } state_t;

  function automatic logic key_match(input logic [7:0] code, input logic [7:0] up, input logic [7:0] lo);
    return (code == up) || (code == lo);
  endfunction

endpackage

// File: rtl/kbd_playback_ctrl_if.sv
// Key-decoder, flash-reader and status signals of the playback controller; master is the controller side.
interface kbd_playback_ctrl_if #(
  parameter int LVL_W = 3
);
  logic             kbd_data_ready;
  logic [7:0]       kbd_received_ascii_code;
  logic             restart_ack;
  logic             end_of_track;
  logic             direction;
  logic             play_enable;
  logic             restart_req;
  logic             sample_tick;
  logic [LVL_W-1:0] speed_level;
  logic [1:0]       state_dbg;

  modport master (
    input  kbd_data_ready, kbd_received_ascii_code, restart_ack, end_of_track,
    output direction, play_enable, restart_req, sample_tick, speed_level, state_dbg
  );

  modport slave (
    output kbd_data_ready, kbd_received_ascii_code, restart_ack, end_of_track,
    input  direction, play_enable, restart_req, sample_tick, speed_level, state_dbg
  );
endinterface

// File: rtl/kbd_playback_ctrl_rate_divider.sv
// Sample-rate divider: load takes priority and presets divisor-1, run counts down and strobes tick at zero.
// Tick is registered; the first tick after load arrives exactly divisor cycles later, count frozen otherwise.
module playback_rate_divider
  import kbd_playback_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int DIV_MIN   = 2,
  parameter int DIV_RESET = 1136
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] divisor,
  input  logic             run,
  input  logic             load,
  output logic             tick
);

  logic [DIV_W-1:0] eff;
  logic [DIV_W-1:0] count;

  assign eff = (divisor < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : divisor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= DIV_W'(DIV_RESET - 1);
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (load) begin
        count <= eff - 1'b1;
      end else if (run) begin
        if (count == '0) begin
          tick  <= 1'b1;
          count <= eff - 1'b1;
        end else begin
          count <= count - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/kbd_playback_ctrl.sv
// Keyboard playback controller: key-edge decode, play/pause/restart FSM, direction, speed level, sample strobe.
// Key actions land two cycles after kbd_data_ready rises; AUTO_LOOP_EN turns end_of_track into a seamless restart.
module kbd_playback_ctrl
  import kbd_playback_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DIV_NOMINAL = 1136,
  parameter int DIV_STEP    = 64,
  parameter int LVL_W       = 3,
  parameter int LVL_DEFAULT = 3,
  parameter int DIV_MIN     = 2
) (
  input  logic                 inclk,
  input  logic                 reset,
  kbd_playback_ctrl_if.master  io
);

  localparam int CW = DIV_W + LVL_W + 1;
  localparam logic signed [CW-1:0] DIV_LO  = CW'(DIV_MIN);
  localparam logic signed [CW-1:0] DIV_HI  = CW'((1 << DIV_W) - 1);
  localparam logic [LVL_W-1:0]     LVL_MAX = '1;
  localparam logic [LVL_W-1:0]     LVL_DEF = LVL_W'(LVL_DEFAULT);

  state_t           state;
  logic             resume;
  logic             play_on;
  logic             req_on;
  logic             dir;
  logic [LVL_W-1:0] level;
  logic             ready_q;
  logic             key_evt;
  logic [7:0]       key_code;

  logic k_e, k_d, k_f, k_b, k_r, k_u, k_n, k_s;
  logic enter_play;
  logic tick;
  logic signed [CW-1:0] div_raw;
  logic [DIV_W-1:0]     divisor;

  assign k_e = key_evt && key_match(key_code, ASC_E_UP, ASC_E_LO);
  assign k_d = key_evt && key_match(key_code, ASC_D_UP, ASC_D_LO);
  assign k_f = key_evt && key_match(key_code, ASC_F_UP, ASC_F_LO);
  assign k_b = key_evt && key_match(key_code, ASC_B_UP, ASC_B_LO);
  assign k_r = key_evt && key_match(key_code, ASC_R_UP, ASC_R_LO);
  assign k_u = key_evt && key_match(key_code, ASC_U_UP, ASC_U_LO);
  assign k_n = key_evt && key_match(key_code, ASC_N_UP, ASC_N_LO);
  assign k_s = key_evt && key_match(key_code, ASC_S_UP, ASC_S_LO);

  // E/D already fold into the resume decision when they coincide with the ack.
  assign enter_play = ((state == ST_IDLE || state == ST_PAUSE) && k_e) ||
                      (state == ST_RESTART && io.restart_ack && (k_e || (resume && !k_d)));

  assign div_raw = CW'(DIV_NOMINAL) + (CW'(LVL_DEFAULT) - signed'(CW'(level))) * CW'(DIV_STEP);

  always_comb begin
    if (div_raw < DIV_LO)      divisor = DIV_W'(DIV_MIN);
    else if (div_raw > DIV_HI) divisor = '1;
    else                       divisor = div_raw[DIV_W-1:0];
  end

  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      resume   <= 1'b0;
      play_on  <= 1'b0;
      req_on   <= 1'b0;
      dir      <= 1'b0;
      level    <= LVL_DEF;
      ready_q  <= 1'b0;
      key_evt  <= 1'b0;
      key_code <= 8'h00;
    end else begin
      ready_q <= io.kbd_data_ready;
      key_evt <= io.kbd_data_ready && !ready_q;
      if (io.kbd_data_ready && !ready_q) key_code <= io.kbd_received_ascii_code;

      if (k_f)      dir <= 1'b0;
      else if (k_b) dir <= 1'b1;

      if (k_u && level != LVL_MAX)   level <= level + 1'b1;
      else if (k_n && level != '0)   level <= level - 1'b1;
      else if (k_s)                  level <= LVL_DEF;

      case (state)
        ST_IDLE, ST_PAUSE: begin
          if (enter_play) begin
            state   <= ST_PLAY;
            play_on <= 1'b1;
          end else if (k_d && state == ST_IDLE) begin
            state <= ST_PAUSE;
          end else if (k_r) begin
            state  <= ST_RESTART;
            req_on <= 1'b1;
            resume <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (k_d) begin
            state   <= ST_PAUSE;
            play_on <= 1'b0;
          end else if (k_r) begin
            state   <= ST_RESTART;
            play_on <= 1'b0;
            req_on  <= 1'b1;
            resume  <= 1'b1;
          end else if (io.end_of_track && !key_evt) begin
`ifdef AUTO_LOOP_EN
            state   <= ST_RESTART;
            play_on <= 1'b0;
            req_on  <= 1'b1;
            resume  <= 1'b1;
`else
            state   <= ST_PAUSE;
            play_on <= 1'b0;
`endif
          end
        end
        ST_RESTART: begin
          if (k_e)      resume <= 1'b1;
          else if (k_d) resume <= 1'b0;
          if (io.restart_ack) begin
            req_on  <= 1'b0;
            play_on <= enter_play;
            state   <= enter_play ? ST_PLAY : ST_PAUSE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          play_on <= 1'b0;
          req_on  <= 1'b0;
        end
      endcase
    end
  end

  playback_rate_divider #(
    .DIV_W     (DIV_W),
    .DIV_MIN   (DIV_MIN),
    .DIV_RESET (DIV_NOMINAL)
  ) u_div (
    .clk     (inclk),
    .rst     (reset),
    .divisor (divisor),
    .run     (play_on),
    .load    (enter_play),
    .tick    (tick)
  );

  assign io.direction   = dir;
  assign io.play_enable = play_on;
  assign io.restart_req = req_on;
  assign io.sample_tick = tick && play_on;
  assign io.speed_level = level;
  assign io.state_dbg   = state;

endmodule

// File: doc/kbd_playback_ctrl.md
Name: kbd_playback_ctrl

Overview:
Parametrised keyboard-driven playback controller for the flash audio player.
- Decodes one-shot key events from the PS/2 ASCII decoder and runs a play/pause/restart state machine.
- Holds direction as a register independent of run state, and holds a programmable playback-speed level.
- Generates the sample-rate strobe consumed by the flash reader, and handshakes restart requests with that reader.

Parameters:
DIV_W, 16, width of sample-rate divider counter
DIV_NOMINAL, 1136, divisor at default speed level (50 MHz / ~44 kHz)
DIV_STEP, 64, divisor change per speed level
LVL_W, 3, speed level width; levels 0..2^LVL_W-1
LVL_DEFAULT, 3, speed level after reset or speed-reset key
DIV_MIN, 2, floor applied to computed divisor

Ports:
inclk  in  1  system clock
reset  in  1  asynchronous active-high reset
kbd_data_ready  in  1  decoder valid level; a key event is its 0->1 edge
kbd_received_ascii_code  in  8  ASCII of last key, sampled at event
restart_ack  in  1  one-cycle pulse from flash reader: address reset done
end_of_track  in  1  one-cycle pulse: reader hit range end in current direction
direction  out  1  0 forward, 1 backward
play_enable  out  1  high in PLAY only
restart_req  out  1  high in RESTART until ack
sample_tick  out  1  one-cycle strobe per divisor period while playing
speed_level  out  LVL_W  current level
state_dbg  out  2  encoded FSM state

Behaviour:
- Clock and reset: one clock (inclk). Reset is asynchronous and active-high.
- Reset values: state IDLE, direction 0, speed_level LVL_DEFAULT, all strobes 0, divider loaded with nominal divisor, edge-detect register 0.
- Key event: the cycle after kbd_data_ready rises, detected by a registered edge detect. Ascii is captured on the same edge. Level-held codes never retrigger. Case-insensitive.
- Key map:
  - E: play
  - D: pause
  - F: direction 0
  - B: direction 1
  - R: restart
  - U: speed up (level+1, saturating at max)
  - N: slow down (level-1, saturating at 0)
  - S: level := LVL_DEFAULT
  - Unknown codes are ignored.
- Direction and speed keys are honoured in every state. They take effect the cycle after the event and never change the FSM state.
- States (state_dbg): IDLE=0, PLAY=1, PAUSE=2, RESTART=3.
  - IDLE: E->PLAY; D->PAUSE; R->RESTART with resume=0.
  - PLAY: D->PAUSE; R->RESTART with resume=1; end_of_track->PAUSE.
  - PAUSE: E->PLAY; R->RESTART with resume=0.
  - RESTART: restart_req=1. On restart_ack go to PLAY if resume, else PAUSE. E sets resume=1, D clears it, R is ignored.
- restart_ack outside RESTART is ignored. end_of_track outside PLAY is ignored.
- Simultaneous key event and end_of_track in PLAY: key wins and end_of_track is dropped. Simultaneous key event and restart_ack: ack transition taken, and E/D updates resume before the decision (same-cycle precedence).
- Divisor = DIV_NOMINAL + (LVL_DEFAULT - level)*DIV_STEP. Computed signed at DIV_W+LVL_W+1 bits, clamped to [DIV_MIN, 2^DIV_W-1].
- Divider behaviour:
  - Reloads divisor-1 on PLAY entry.
  - Decrements each PLAY cycle. At 0 it asserts sample_tick for one cycle and reloads.
  - Frozen outside PLAY.
  - A speed change applies at the next reload.
  - First tick occurs exactly divisor cycles after PLAY entry.
- Reset mid-RESTART: restart_req drops asynchronously and the FSM goes to IDLE. The reader must tolerate an abandoned request.

Optional Feature:
AUTO_LOOP_EN.
- Defined: end_of_track in PLAY goes to RESTART with resume=1, giving a seamless loop in the current direction.
- Undefined: end_of_track in PLAY goes to PAUSE.

Decomposition:
- Package kbd_playback_pkg holds the ASCII code constants (upper and lower case for E, D, F, B, R, U, N, S) and the 2-bit state encoding constants.
- Sub-module playback_rate_divider: parameters DIV_W and DIV_MIN; inputs divisor, run, load; output tick.

Test Plan:
1. Reset, pulse kbd_data_ready with 'e' -> play_enable=1 two cycles later, first sample_tick 1136 cycles after PLAY entry, then every 1136.
2. Hold kbd_data_ready high with 'd' for 100 cycles -> exactly one transition to PAUSE; hold 'U' high -> speed_level increments once only.
3. From level 3 press 'U' 6 times -> level saturates at 7, divisor 880; press 'S' -> level 3, next period 1136.
4. In PLAY press 'r' -> restart_req high, no ticks; ack after 10 cycles -> PLAY resumes; repeat from PAUSE -> returns to PAUSE.
5. In PLAY press 'b' -> direction=1, state stays PLAY; end_of_track pulse -> PAUSE (AUTO_LOOP_EN off) or RESTART then PLAY (on).
6. Assert reset while restart_req=1 -> all outputs at reset values same cycle, state_dbg=0; a late restart_ack is ignored.
